axi_ad9963_tx_unpack: RTL and testbench

//  Upstream feeder for the AD9963 TX core: buffers 32-bit DMA words in a FIFO and unpacks them.

---
 rtl/axi_ad9963_tx_unpack.sv | 147 ++++++++++++++
 tb/tb_axi_ad9963_tx_unpack.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/axi_ad9963_tx_unpack.sv
// DMA-to-DAC unpacker for the AD9963 TX path: a word FIFO followed by a
// per-channel sample unpacker that prefetches on each consume strobe.
//
// phase     | meaning
// PH_FIRST  | next SINGLE consume pops a word and emits its low half
// PH_SECOND | next SINGLE consume emits the buffered high half, no pop
module axi_ad9963_tx_unpack #(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter bit UNDERFLOW_HOLD  = 1'b0
) (
  input  logic                     dac_clk,
  input  logic                     dac_rst,
  input  logic                     dma_valid,
  input  logic [31:0]              dma_data,
  output logic                     dma_ready,
  input  logic                     dac_enable_i,
  input  logic                     dac_enable_q,
  input  logic                     dac_valid_i,
  input  logic                     dac_valid_q,
  output logic [15:0]              dac_data_i,
  output logic [15:0]              dac_data_q,
  output logic                     dac_dunf,
  output logic [FIFO_ADDR_WIDTH:0] fifo_level
);

  localparam int AW    = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic {PH_FIRST, PH_SECOND} phase_t;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [1:0]    en_prev_q;
  logic          ready_q;
  logic [15:0]   data_i_q, data_q_q, spare_q;
  logic          dunf_q;
  phase_t        phase_q;

  logic [1:0]  en;
  logic        flush, push, consume, need_pop, underflow, pop;
  logic [31:0] rd_word;

  always_comb begin
    en        = {dac_enable_q, dac_enable_i};
    // Any enable change, or both channels off, empties the whole datapath.
    flush     = (en != en_prev_q) | (en == 2'b00);
    push      = dma_valid & ready_q & ~flush & (level_q != LVL_FULL);
    consume   = (dac_valid_i | dac_valid_q) & ~flush;
    need_pop  = consume & ((en == 2'b11) | (phase_q == PH_FIRST));
    underflow = need_pop & (level_q == '0);
    pop       = need_pop & ~underflow;
    rd_word   = mem_q[rd_ptr_q];
    level_d   = level_q;
    if (push & ~pop)
      level_d = level_q + LVL_ONE;
    else if (pop & ~push)
      level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge dac_clk) begin
    if (push)
      mem_q[wr_ptr_q] <= dma_data;
  end

  always_ff @(posedge dac_clk or posedge dac_rst) begin
    if (dac_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      en_prev_q <= 2'b00;
      ready_q   <= 1'b0;
      data_i_q  <= '0;
      data_q_q  <= '0;
      spare_q   <= '0;
      dunf_q    <= 1'b0;
      phase_q   <= PH_FIRST;
    end else begin
      en_prev_q <= en;
      dunf_q    <= underflow;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        ready_q  <= 1'b0;
        data_i_q <= '0;
        data_q_q <= '0;
        spare_q  <= '0;
        phase_q  <= PH_FIRST;
      end else begin
        level_q <= level_d;
        // Looking at the next level keeps a push from ever landing on a full FIFO.
        ready_q <= (level_d != LVL_FULL);
        if (push)
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_ONE;
        if (underflow) begin
          if (!UNDERFLOW_HOLD) begin
            data_i_q <= '0;
            data_q_q <= '0;
          end
        end else if (consume) begin
          case (en)
            2'b11: begin
              data_i_q <= rd_word[15:0];
              data_q_q <= rd_word[31:16];
            end
            2'b01: begin
              data_q_q <= '0;
              if (phase_q == PH_FIRST) begin
                data_i_q <= rd_word[15:0];
                spare_q  <= rd_word[31:16];
                phase_q  <= PH_SECOND;
              end else begin
                data_i_q <= spare_q;
                phase_q  <= PH_FIRST;
              end
            end
            2'b10: begin
              data_i_q <= '0;
              if (phase_q == PH_FIRST) begin
                data_q_q <= rd_word[15:0];
                spare_q  <= rd_word[31:16];
                phase_q  <= PH_SECOND;
              end else begin
                data_q_q <= spare_q;
                phase_q  <= PH_FIRST;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign dma_ready  = ready_q;
  assign dac_data_i = data_i_q;
  assign dac_data_q = data_q_q;
  assign dac_dunf   = dunf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_axi_ad9963_tx_unpack.sv
// Directed bench for axi_ad9963_tx_unpack; expected {I,Q,dunf} tuples are
// queued when a consume is driven and compared once the DUT has loaded them.
module tb_axi_ad9963_tx_unpack;

  logic        dac_clk = 1'b0;
  logic        dac_rst = 1'b1;
  logic        dma_valid = 1'b0;
  logic [31:0] dma_data = '0;
  logic        dma_ready;
  logic        dac_enable_i = 1'b1;
  logic        dac_enable_q = 1'b1;
  logic        dac_valid_i = 1'b0;
  logic        dac_valid_q = 1'b0;
  logic [15:0] dac_data_i, dac_data_q;
  logic        dac_dunf;
  logic [4:0]  fifo_level;

  int vectors = 0;
  int errors  = 0;
  logic [32:0] sb[$];

  axi_ad9963_tx_unpack #(.FIFO_ADDR_WIDTH(4), .UNDERFLOW_HOLD(1'b0)) dut (
    .dac_clk(dac_clk), .dac_rst(dac_rst),
    .dma_valid(dma_valid), .dma_data(dma_data), .dma_ready(dma_ready),
    .dac_enable_i(dac_enable_i), .dac_enable_q(dac_enable_q),
    .dac_valid_i(dac_valid_i), .dac_valid_q(dac_valid_q),
    .dac_data_i(dac_data_i), .dac_data_q(dac_data_q),
    .dac_dunf(dac_dunf), .fifo_level(fifo_level)
  );

  always #5 dac_clk = ~dac_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (dma_ready !== 1'b1 && n < 20) begin
      @(negedge dac_clk);
      n++;
    end
    check("ready_wait", 64'(dma_ready), 64'd1);
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge dac_clk);
    wait_ready();
    dma_valid = 1'b1;
    dma_data  = w;
    @(negedge dac_clk);
    dma_valid = 1'b0;
  endtask

  task automatic consume(input logic use_q, input logic [32:0] exp);
    logic [32:0] want;
    @(negedge dac_clk);
    if (use_q) dac_valid_q = 1'b1;
    else       dac_valid_i = 1'b1;
    sb.push_back(exp);
    @(posedge dac_clk);
    #1;
    dac_valid_i = 1'b0;
    dac_valid_q = 1'b0;
    want = sb.pop_front();
    check("consume", 64'({dac_data_i, dac_data_q, dac_dunf}), 64'(want));
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready", 64'(dma_ready), 64'd0);
    check("rst_data", 64'({dac_data_i, dac_data_q}), 64'd0);
    check("rst_dunf", 64'(dac_dunf), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    @(negedge dac_clk);
    dac_rst = 1'b0;

    // 1. PAIR unpack
    push(32'h2222_1111);
    push(32'h4444_3333);
    check("pair_level", 64'(fifo_level), 64'd2);
    consume(1'b0, {16'h1111, 16'h2222, 1'b0});
    consume(1'b1, {16'h3333, 16'h4444, 1'b0});
    check("pair_empty", 64'(fifo_level), 64'd0);

    // 2. SINGLE_I: two samples per word, then underflow
    @(negedge dac_clk);
    dac_enable_q = 1'b0;
    push(32'hBBBB_AAAA);
    consume(1'b0, {16'hAAAA, 16'h0000, 1'b0});
    consume(1'b0, {16'hBBBB, 16'h0000, 1'b0});
    consume(1'b0, {16'h0000, 16'h0000, 1'b1});
    @(posedge dac_clk);
    #1;
    check("dunf_one_cycle", 64'(dac_dunf), 64'd0);

    // 3. Full FIFO, release by one pop, then drain in order
    @(negedge dac_clk);
    dac_enable_q = 1'b1;
    for (int i = 0; i < 16; i++)
      push({16'hB000 + 16'(i), 16'hA000 + 16'(i)});
    check("full_level", 64'(fifo_level), 64'd16);
    check("full_ready", 64'(dma_ready), 64'd0);
    consume(1'b0, {16'hA000, 16'hB000, 1'b0});
    check("full_release", 64'(dma_ready), 64'd1);
    for (int i = 1; i < 16; i++)
      consume(1'b1, {16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b0});
    check("drain_level", 64'(fifo_level), 64'd0);

    // 4. Consume and push together on an empty FIFO
    @(negedge dac_clk);
    check("empty_ready", 64'(dma_ready), 64'd1);
    dma_valid   = 1'b1;
    dma_data    = 32'h6666_5555;
    dac_valid_i = 1'b1;
    sb.push_back({16'h0000, 16'h0000, 1'b1});
    @(posedge dac_clk);
    #1;
    dma_valid   = 1'b0;
    dac_valid_i = 1'b0;
    check("empty_unf", 64'({dac_data_i, dac_data_q, dac_dunf}), 64'(sb.pop_front()));
    check("empty_stored", 64'(fifo_level), 64'd1);
    consume(1'b0, {16'h5555, 16'h6666, 1'b0});

    // 5. Enable change 11 -> 01 with 5 words buffered
    for (int i = 0; i < 5; i++)
      push({16'h7700 + 16'(i), 16'h7000 + 16'(i)});
    check("chg_level_before", 64'(fifo_level), 64'd5);
    @(negedge dac_clk);
    dac_enable_q = 1'b0;
    @(posedge dac_clk);
    #1;
    check("chg_level", 64'(fifo_level), 64'd0);
    check("chg_data", 64'({dac_data_i, dac_data_q}), 64'd0);
    check("chg_dunf", 64'(dac_dunf), 64'd0);
    check("chg_ready", 64'(dma_ready), 64'd0);
    push(32'hDDDD_CCCC);
    consume(1'b0, {16'hCCCC, 16'h0000, 1'b0});
    consume(1'b0, {16'hDDDD, 16'h0000, 1'b0});

    // 6. Asynchronous reset mid-stream
    @(negedge dac_clk);
    dac_enable_q = 1'b1;
    for (int i = 0; i < 7; i++)
      push({16'h9900 + 16'(i), 16'h9000 + 16'(i)});
    consume(1'b0, {16'h9000, 16'h9900, 1'b0});
    push(32'h9907_9007);
    check("rst_mid_level", 64'(fifo_level), 64'd7);
    @(negedge dac_clk);
    #2;
    dac_rst = 1'b1;
    #1;
    check("arst_data", 64'({dac_data_i, dac_data_q}), 64'd0);
    check("arst_ready", 64'(dma_ready), 64'd0);
    check("arst_level", 64'(fifo_level), 64'd0);
    check("arst_dunf", 64'(dac_dunf), 64'd0);
    @(negedge dac_clk);
    dac_rst = 1'b0;
    @(negedge dac_clk);
    wait_ready();
    consume(1'b0, {16'h0000, 16'h0000, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
